// File: rtl/rsa_host_if.sv
// Framed UART host interface for the modular-exponentiation core: command decode, LSB-first
// operand load, key caching, answer serialisation. Optional frame timeout: RSA_HOST_IF_TIMEOUT_EN.
module rsa_host_if #(
   parameter int BITLEN         = 64,
   parameter int LOG_BITLEN     = 6,
   parameter int TIMEOUT_CYCLES = 125000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx_valid,
   input  logic [7:0]            rx_byte,
   input  logic                  tx_busy,
   output logic                  tx_valid,
   output logic [7:0]            tx_byte,
   output logic [BITLEN-1:0]     msg,
   output logic [BITLEN-1:0]     e,
   output logic [BITLEN-1:0]     n,
   output logic [LOG_BITLEN-1:0] e_idx,
   output logic                  start,
   input  logic                  stop,
   input  logic [BITLEN-1:0]     ans,
   output logic                  busy,
   output logic                  drop
);

   localparam int                  NBYTES = BITLEN / 8;
   localparam logic [LOG_BITLEN-1:0] LAST = LOG_BITLEN'(NBYTES - 1);
   localparam logic [7:0]          CMD_FULL = 8'hA5;
   localparam logic [7:0]          CMD_MSG  = 8'h5A;
   localparam logic [7:0]          NAK      = 8'hEE;

   typedef enum logic [3:0] {
      IDLE, RX_M, RX_E, RX_N, START, WAIT, TX_PULSE, TX_HOLD, TX_WAIT
   } state_t;

   state_t                state;
   logic [LOG_BITLEN-1:0] cnt;
   logic [BITLEN-1:0]     sh;
   logic                  full;
   logic                  nak;
   logic                  key_valid;

`ifdef RSA_HOST_IF_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
   logic [TW-1:0] to_cnt;
`endif

   function automatic logic [LOG_BITLEN-1:0] msb_idx(input logic [BITLEN-1:0] v);
      msb_idx = '0;
      for (int i = 0; i < BITLEN; i++)
         if (v[i]) msb_idx = LOG_BITLEN'(i);
   endfunction

   // NOTE: drop must answer in the same cycle as rx_valid, so it is decoded from the
   // current state rather than registered.
   assign drop = rx_valid && (state inside {START, WAIT, TX_PULSE, TX_HOLD, TX_WAIT});

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         sh        <= '0;
         full      <= 1'b0;
         nak       <= 1'b0;
         key_valid <= 1'b0;
         tx_valid  <= 1'b0;
         tx_byte   <= '0;
         msg       <= '0;
         e         <= '0;
         n         <= '0;
         e_idx     <= '0;
         start     <= 1'b0;
         busy      <= 1'b0;
`ifdef RSA_HOST_IF_TIMEOUT_EN
         to_cnt    <= '0;
`endif
      end else begin
         // NOTE: pulses default low here; the state that raises them overrides with a later <=.
         start    <= 1'b0;
         tx_valid <= 1'b0;
         case (state)
            IDLE: if (rx_valid) begin
               if (rx_byte == CMD_FULL || (rx_byte == CMD_MSG && key_valid)) begin
                  full  <= (rx_byte == CMD_FULL);
                  cnt   <= '0;
                  state <= RX_M;
               end else begin
                  nak   <= 1'b1;
                  sh    <= BITLEN'(NAK);
                  state <= TX_PULSE;
               end
            end
            RX_M: if (rx_valid) begin
               msg[{cnt, 3'b000} +: 8] <= rx_byte;
               cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
               if (cnt == LAST) begin
                  if (full) begin
                     state <= RX_E;
                  end else begin
                     start <= 1'b1;
                     busy  <= 1'b1;
                     state <= START;
                  end
               end
            end
            RX_E: if (rx_valid) begin
               e[{cnt, 3'b000} +: 8] <= rx_byte;
               cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
               if (cnt == LAST) state <= RX_N;
            end
            RX_N: if (rx_valid) begin
               n[{cnt, 3'b000} +: 8] <= rx_byte;
               cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
               if (cnt == LAST) begin
                  key_valid <= 1'b1;
                  e_idx     <= msb_idx(e);
                  start     <= 1'b1;
                  busy      <= 1'b1;
                  state     <= START;
               end
            end
            START: state <= WAIT;
            WAIT: if (stop) begin
               sh    <= ans;
               cnt   <= '0;
               nak   <= 1'b0;
               state <= TX_PULSE;
            end
            TX_PULSE: if (!tx_busy) begin
               tx_valid <= 1'b1;
               tx_byte  <= sh[7:0];
               state    <= TX_HOLD;
            end
            // The UART may need a cycle to raise tx_busy, so it is not consulted here.
            TX_HOLD: state <= TX_WAIT;
            TX_WAIT: if (!tx_busy) begin
               if (nak || cnt == LAST) begin
                  nak   <= 1'b0;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  sh    <= sh >> 8;
                  cnt   <= cnt + 1'b1;
                  state <= TX_PULSE;
               end
            end
            default: state <= IDLE;
         endcase

`ifdef RSA_HOST_IF_TIMEOUT_EN
         // Partial operand contents are left as written; only the frame is abandoned.
         if (state inside {RX_M, RX_E, RX_N}) begin
            if (rx_valid) begin
               to_cnt <= '0;
            end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
               to_cnt <= '0;
               nak    <= 1'b1;
               sh     <= BITLEN'(NAK);
               state  <= TX_PULSE;
               if (state != RX_M) key_valid <= 1'b0;
            end else begin
               to_cnt <= to_cnt + 1'b1;
            end
         end else begin
            to_cnt <= '0;
         end
`endif
      end
   end

endmodule

// File: tb/tb_rsa_host_if.sv
// Self-checking bench for rsa_host_if at BITLEN=16: table of frames, hand-written corner
// sequences and randomized transactions against a transaction-level model.
module tb_rsa_host_if;

   localparam int BL = 16;
   localparam int LB = 4;
   localparam int NB = BL / 8;

   logic          clk = 1'b0;
   logic          rst, rx_valid, tx_busy, stop;
   logic [7:0]    rx_byte;
   logic          tx_valid, start, busy, drop;
   logic [7:0]    tx_byte;
   logic [BL-1:0] msg, e, n, ans;
   logic [LB-1:0] e_idx;

   rsa_host_if #(.BITLEN(BL), .LOG_BITLEN(LB), .TIMEOUT_CYCLES(100)) dut (
      .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte), .tx_busy(tx_busy),
      .tx_valid(tx_valid), .tx_byte(tx_byte), .msg(msg), .e(e), .n(n), .e_idx(e_idx),
      .start(start), .stop(stop), .ans(ans), .busy(busy), .drop(drop)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [BL-1:0] m, e, n;
      logic [LB-1:0] idx;
   } cap_t;

   typedef struct {
      logic [7:0]    cmd;
      logic [BL-1:0] m, e, n, ans, exp_e, exp_n;
      logic [LB-1:0] exp_idx;
   } vec_t;

   int vectors = 0, miscompares = 0;

   // monitor state (written only by the monitor)
   logic [7:0] tx_q[$];
   cap_t       start_q[$];
   int         drop_cnt = 0, busy_cnt = 0, busy_fall_tx = -1, cyc = 0, last_tx = -100;
   logic       busy_q = 1'b0;

   // transaction-level model
   logic          key_m = 1'b0;
   logic [BL-1:0] msg_m = '0, e_m = '0, n_m = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int exp_idx(input logic [BL-1:0] v);
      return (v == 0) ? 0 : $clog2(int'(v) + 1) - 1;
   endfunction

   always @(negedge clk) begin
      cyc++;
      if (tx_valid) begin
         tx_q.push_back(tx_byte);
         check("tx_spacing", 64'(cyc - last_tx >= 3), 64'd1);
         last_tx = cyc;
      end
      if (start) start_q.push_back('{msg, e, n, e_idx});
      if (drop) drop_cnt++;
      if (busy) busy_cnt++;
      if (busy_q && !busy) busy_fall_tx = tx_q.size();
      busy_q = busy;
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic send(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_byte  = b;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic send_drop(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_byte  = b;
      #1 check("drop_now", 64'(drop), 64'd1);
      tick();
      rx_valid = 1'b0;
   endtask

   // Runs until n tx_valid pulses were seen and the line has been quiet for a few cycles.
   task automatic wait_tx(input int nexp, input bit rand_busy, input int ndrops);
      int cnt = 0, hold = 0, extra = 0, bud = 0;
      while (bud < 3000) begin
         if (ndrops > 0) begin
            rx_valid = 1'b1;
            rx_byte  = 8'($urandom);
            ndrops--;
         end else begin
            rx_valid = 1'b0;
         end
         tick();
         bud++;
         if (hold > 0) begin
            hold--;
            if (hold == 0) tx_busy = 1'b0;
         end
         if (tx_valid) begin
            cnt++;
            if (rand_busy) begin
               hold    = $urandom_range(1, 6);
               tx_busy = 1'b1;
            end
         end
         if (cnt >= nexp && !tx_busy && ndrops == 0) begin
            extra++;
            if (extra >= 4) break;
         end
      end
      rx_valid = 1'b0;
      tx_busy  = 1'b0;
      if (bud >= 3000) check("tx_wait_budget", 64'd0, 64'd1);
   endtask

   task automatic run_txn(input logic [7:0] cmd, input logic [BL-1:0] mv, ev, nv, av,
                          input bit drops, input bit rand_busy);
      int  tb0 = tx_q.size(), sb0 = start_q.size(), db0 = drop_cnt, bb0 = busy_cnt;
      int  nd_wait, nd_tx;
      bit  ok = (cmd == 8'hA5) || (cmd == 8'h5A && key_m);
      send(cmd);
      if (!ok) begin
         wait_tx(1, rand_busy, 0);
         check("nak_count", 64'(tx_q.size() - tb0), 64'd1);
         if (tx_q.size() > tb0) check("nak_byte", 64'(tx_q[tb0]), 64'hEE);
         check("nak_no_start", 64'(start_q.size() - sb0), 64'd0);
         check("nak_no_busy", 64'(busy_cnt - bb0), 64'd0);
         return;
      end
      for (int k = 0; k < NB; k++) send(mv[8*k +: 8]);
      msg_m = mv;
      if (cmd == 8'hA5) begin
         for (int k = 0; k < NB; k++) send(ev[8*k +: 8]);
         for (int k = 0; k < NB; k++) send(nv[8*k +: 8]);
         e_m   = ev;
         n_m   = nv;
         key_m = 1'b1;
      end
      check("start_rise", 64'(start), 64'd1);
      check("busy_rise", 64'(busy), 64'd1);
      check("msg", 64'(msg), 64'(msg_m));
      check("e", 64'(e), 64'(e_m));
      check("n", 64'(n), 64'(n_m));
      check("e_idx", 64'(e_idx), 64'(exp_idx(e_m)));
      tick();
      check("start_pulse", 64'(start), 64'd0);
      nd_wait = drops ? $urandom_range(1, 3) : 0;
      for (int i = 0; i < nd_wait; i++) send_drop(8'($urandom));
      repeat ($urandom_range(0, 3)) tick();
      check("no_early_tx", 64'(tx_q.size() - tb0), 64'd0);
      stop = 1'b1;
      ans  = av;
      tick();
      stop = 1'b0;
      ans  = BL'($urandom);
      nd_tx = drops ? 3 : 0;
      wait_tx(NB, rand_busy, nd_tx);
      check("tx_count", 64'(tx_q.size() - tb0), 64'(NB));
      for (int k = 0; k < NB; k++)
         if (tx_q.size() > tb0 + k) check("tx_byte", 64'(tx_q[tb0 + k]), 64'(av[8*k +: 8]));
      check("drop_count", 64'(drop_cnt - db0), 64'(nd_wait + nd_tx));
      check("start_once", 64'(start_q.size() - sb0), 64'd1);
      check("busy_fall", 64'(busy), 64'd0);
      check("busy_fall_after_last", 64'(busy_fall_tx), 64'(tb0 + NB));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_tx_valid"}, 64'(tx_valid), 64'd0);
      check({tag, "_tx_byte"}, 64'(tx_byte), 64'd0);
      check({tag, "_msg"}, 64'(msg), 64'd0);
      check({tag, "_e"}, 64'(e), 64'd0);
      check({tag, "_n"}, 64'(n), 64'd0);
      check({tag, "_e_idx"}, 64'(e_idx), 64'd0);
      check({tag, "_start"}, 64'(start), 64'd0);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_drop"}, 64'(drop), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t tbl[5];
      int   tb0, sb0, bud;
      logic [7:0] b;

      tbl[0] = '{8'hA5, 16'h1234, 16'h0003, 16'h00C5, 16'h00AB, 16'h0003, 16'h00C5, 4'd1};
      tbl[1] = '{8'h5A, 16'h0002, 16'hxxxx, 16'hxxxx, 16'h5566, 16'h0003, 16'h00C5, 4'd1};
      tbl[2] = '{8'hA5, 16'hFFFF, 16'h8000, 16'hFFFF, 16'h1234, 16'h8000, 16'hFFFF, 4'd15};
      tbl[3] = '{8'hA5, 16'h0001, 16'h0000, 16'h0003, 16'hBEEF, 16'h0000, 16'h0003, 4'd0};
      tbl[4] = '{8'h5A, 16'h7E7E, 16'hxxxx, 16'hxxxx, 16'h0001, 16'h0000, 16'h0003, 4'd0};

      rst = 1'b1; rx_valid = 1'b0; rx_byte = '0; tx_busy = 1'b0; stop = 1'b0; ans = '0;
      repeat (3) tick();
      check_all_zero("reset");
      rst = 1'b0;
      tick();

      // no cached key after reset, then an unknown command
      run_txn(8'h5A, '0, '0, '0, '0, 1'b0, 1'b0);
      run_txn(8'h77, '0, '0, '0, '0, 1'b0, 1'b0);

      // stop outside WAIT does nothing
      tb0 = tx_q.size();
      stop = 1'b1; ans = 16'hDEAD; tick(); stop = 1'b0;
      repeat (6) tick();
      check("stop_in_idle", 64'(tx_q.size() - tb0), 64'd0);

      for (int i = 0; i < 5; i++) begin
         sb0 = start_q.size();
         run_txn(tbl[i].cmd, tbl[i].m, tbl[i].e, tbl[i].n, tbl[i].ans, i == 2, 1'b0);
         if (start_q.size() > sb0) begin
            check("tbl_msg", 64'(start_q[sb0].m), 64'(tbl[i].m));
            check("tbl_e", 64'(start_q[sb0].e), 64'(tbl[i].exp_e));
            check("tbl_n", 64'(start_q[sb0].n), 64'(tbl[i].exp_n));
            check("tbl_e_idx", 64'(start_q[sb0].idx), 64'(tbl[i].exp_idx));
         end else begin
            check("tbl_start_seen", 64'd0, 64'd1);
         end
      end

      // tx_busy held after the first answer byte stalls the second
      send(8'h5A); send(8'h11); send(8'h22); msg_m = 16'h2211;
      tick();
      tb0 = tx_q.size();
      stop = 1'b1; ans = 16'hC0DE; tick(); stop = 1'b0;
      bud = 0;
      while (!tx_valid && bud < 20) begin tick(); bud++; end
      check("hold_first_tx", 64'(tx_valid), 64'd1);
      tx_busy = 1'b1;
      repeat (1000) tick();
      check("hold_one_byte", 64'(tx_q.size() - tb0), 64'd1);
      check("hold_busy", 64'(busy), 64'd1);
      tx_busy = 1'b0;
      wait_tx(1, 1'b0, 0);
      check("hold_total", 64'(tx_q.size() - tb0), 64'd2);
      if (tx_q.size() >= tb0 + 2) begin
         check("hold_b0", 64'(tx_q[tb0]), 64'hDE);
         check("hold_b1", 64'(tx_q[tb0 + 1]), 64'hC0);
      end
      check("hold_done", 64'(busy), 64'd0);

`ifdef RSA_HOST_IF_TIMEOUT_EN
      tb0 = tx_q.size(); sb0 = start_q.size();
      send(8'hA5); send(8'h34);
      wait_tx(1, 1'b0, 0);
      check("to_m_count", 64'(tx_q.size() - tb0), 64'd1);
      if (tx_q.size() > tb0) check("to_m_nak", 64'(tx_q[tb0]), 64'hEE);
      check("to_m_partial", 64'(msg[7:0]), 64'h34);
      msg_m[7:0] = 8'h34;
      tb0 = tx_q.size();
      send(8'hA5); send(8'h01); send(8'h02); send(8'h03);
      wait_tx(1, 1'b0, 0);
      check("to_e_count", 64'(tx_q.size() - tb0), 64'd1);
      if (tx_q.size() > tb0) check("to_e_nak", 64'(tx_q[tb0]), 64'hEE);
      check("to_no_start", 64'(start_q.size() - sb0), 64'd0);
      msg_m = 16'h0201; e_m[7:0] = 8'h03; key_m = 1'b0;
      run_txn(8'h5A, '0, '0, '0, '0, 1'b0, 1'b0);
      run_txn(8'hA5, 16'h1234, 16'h0003, 16'h00C5, 16'h00AB, 1'b0, 1'b0);
`else
      tb0 = tx_q.size();
      send(8'hA5); send(8'h34);
      repeat (150) tick();
      check("no_timeout", 64'(tx_q.size() - tb0), 64'd0);
      send(8'h12); send(8'h03); send(8'h00); send(8'hC5); send(8'h00);
      check("late_start", 64'(start), 64'd1);
      check("late_msg", 64'(msg), 64'h1234);
      msg_m = 16'h1234; e_m = 16'h0003; n_m = 16'h00C5; key_m = 1'b1;
      tick();
      stop = 1'b1; ans = 16'h9988; tick(); stop = 1'b0;
      wait_tx(NB, 1'b0, 0);
      check("late_tx", 64'(tx_q.size() - tb0), 64'(NB));
`endif

      // reset in the middle of the exponent
      send(8'hA5); send(8'h55); send(8'h66); send(8'h77);
      rst = 1'b1;
      tick();
      check_all_zero("midreset");
      rst = 1'b0;
      key_m = 1'b0; msg_m = '0; e_m = '0; n_m = '0;
      tick();
      run_txn(8'h5A, '0, '0, '0, '0, 1'b0, 1'b0);

      for (int i = 0; i < 25; i++) begin
         int r = $urandom_range(0, 9);
         if (r < 4) b = 8'hA5;
         else if (r < 8) b = 8'h5A;
         else begin
            b = 8'($urandom);
            if (b == 8'hA5 || b == 8'h5A) b = 8'h00;
         end
         run_txn(b, BL'($urandom), BL'($urandom >> $urandom_range(0, 16)), BL'($urandom),
                 BL'($urandom), 1'($urandom), 1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/rsa_host_if.md
# rsa_host_if

Framed host-interface controller between the UART byte stream and the modular-exponentiation core, generalised to any BITLEN. It decodes a command byte, loads message, exponent and modulus operands LSB-first, and pulses the core start. It caches the key for message-only runs and serialises the answer back to the UART. It is busy-locked: bytes arriving while a computation or transmission is in flight are dropped and flagged, never corrupting state.

## Interface
- `BITLEN`, 64: operand width in bits; multiple of 8, ≥16.
- `LOG_BITLEN`, 6: clog2(BITLEN).
- `TIMEOUT_CYCLES`, 125000: idle cycles before a partial frame is aborted (timeout build only).

- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `rx_valid`  in  1  one-cycle pulse, `rx_byte` valid.
- `rx_byte`  in  8  received byte.
- `tx_busy`  in  1  UART transmitter busy.
- `tx_valid`  out  1  one-cycle transmit request.
- `tx_byte`  out  8  byte to transmit, held stable while `tx_valid` is high.
- `msg`, `e`, `n`  out  BITLEN  operand registers to the core.
- `e_idx`  out  LOG_BITLEN  index of the highest set bit of `e` (0 if `e`==0).
- `start`  out  1  one-cycle core start pulse.
- `stop`  in  1  one-cycle core done pulse.
- `ans`  in  BITLEN  core result, sampled on `stop`.
- `busy`  out  1  high from `start` through the last answer byte.
- `drop`  out  1  one-cycle pulse when an `rx_valid` byte is discarded.

## Operation
- Let B = BITLEN/8. States: IDLE, RX_M, RX_E, RX_N, START, WAIT, TX_PULSE, TX_HOLD, TX_WAIT.
- IDLE: on a byte, 0xA5 → RX_M (full load). 0x5A → RX_M (message-only) if the key is cached. 0x5A with no cached key, or any other byte → send the single NAK byte 0xEE via TX_PULSE.
- RX_M/RX_E/RX_N: each takes exactly B bytes; byte k lands in bits [8k+7:8k]. A message-only frame goes RX_M → START, skipping RX_E and RX_N.
- On the last N byte, set `key_valid` and compute `e_idx`, registered, by the cycle `start` is asserted.
- START: `start`=1 for one cycle → WAIT. In WAIT, `stop` latches `ans` into the shift register → TX_PULSE.
- TX: B answer bytes, LSB first. TX_PULSE asserts `tx_valid` only when `tx_busy`=0. TX_HOLD lasts one cycle and ignores `tx_busy`. TX_WAIT waits for `tx_busy`=0, then sends the next byte or returns to IDLE.
- `rx_valid` in START/WAIT/TX_* → byte discarded, `drop` pulses the same cycle, state unchanged.
- `stop` outside WAIT is ignored.
- Reset values: all outputs 0, `key_valid`=0, state IDLE. Reset mid-frame, mid-compute or mid-transmit aborts immediately with no further `tx_valid`.

## Timing
- `start` rises one cycle after the `rx_valid` carrying the final operand byte.
- First `tx_valid` comes no earlier than one cycle after `stop`.
- Consecutive `tx_valid` pulses are at least 3 cycles apart.
- `busy` rises with `start` and falls the cycle the state returns to IDLE after the last byte's TX_WAIT. `busy` is not asserted for a NAK.
- `drop` has zero latency.
- If `rx_valid` and a state transition fall in the same cycle, the state at the cycle start decides the outcome.

## Configuration
- `RSA_HOST_IF_TIMEOUT_EN` defined: a counter runs in RX_M/RX_E/RX_N and clears on each `rx_valid`. When it reaches TIMEOUT_CYCLES, the frame is discarded, the block returns to IDLE and sends NAK 0xEE. Operand registers already written keep their partial contents. `key_valid` is cleared if the timeout hits in RX_E or RX_N.
- Undefined: no counter; a partial frame waits indefinitely and only `rst` recovers.

## Test plan
- BITLEN=16. Send A5 34 12 03 00 C5 00 (m=0x1234, e=3, n=0xC5) → `start` once one cycle after the last byte, with msg=0x1234, e=3, n=0xC5, e_idx=1. Answer 0x00AB on `stop` → `tx_byte` AB then 00, and `busy` falls after the second byte.
- After the above, send 5A 02 00 → `start` with msg=2, unchanged e/n. After reset, 5A → single NAK 0xEE, no `start`.
- Byte 0x77 in IDLE → NAK 0xEE, no `busy`.
- Send bytes during WAIT and mid-TX → one `drop` pulse per byte; the answer bytes are sent intact and state is unchanged.
- Hold `tx_busy`=1 for 1000 cycles after the first answer byte → no second `tx_valid` until it falls.
- Timeout build, TIMEOUT_CYCLES=100: send A5 34 then idle 100 cycles → NAK 0xEE, back to IDLE. Non-timeout build, same stimulus → remains in RX_M. Assert `rst` mid-RX_E → all outputs 0 next cycle.
